ip_ingress_scheduler: RTL and testbench

//  Round-robin scheduler that shares the single byte-serial IP engine (ip_send_recv: in/ready/h_busy)

---
 rtl/ip_ingress_scheduler_if.sv | 27 ++
 rtl/ip_ingress_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_ip_ingress_scheduler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_ingress_scheduler_if.sv
// Port-side and engine-side signals of the ingress scheduler, bundled as one interface.
// The scheduler uses the slave modport; the ports/engine side uses master.
interface ip_ingress_scheduler_if #(
  parameter int unsigned NPORTS = 4
) ();
  logic [NPORTS-1:0]   port_req;
  logic [8*NPORTS-1:0] port_data;
  logic [NPORTS-1:0]   port_valid;
  logic [NPORTS-1:0]   port_pop;
  logic [NPORTS-1:0]   grant;
  logic [7:0]          eng_in;
  logic                eng_ready;
  logic                eng_busy;
  logic                pkt_done;
  logic                err_len;
  logic                err_stall;

  modport master (
    output port_req, port_data, port_valid, eng_busy,
    input  port_pop, grant, eng_in, eng_ready, pkt_done, err_len, err_stall
  );

  modport slave (
    input  port_req, port_data, port_valid, eng_busy,
    output port_pop, grant, eng_in, eng_ready, pkt_done, err_len, err_stall
  );
endinterface

// File: rtl/ip_ingress_scheduler.sv
// Round-robin arbiter sharing one byte-serial IP engine among NPORTS ports, one whole
// IPv4 packet per grant; packet end comes from the header Total Length field.
module ip_ingress_scheduler #(
  parameter int unsigned NPORTS    = 4,
  parameter int unsigned HDR_BYTES = 20,
  parameter int unsigned STALL_MAX = 255,
  parameter int unsigned IDLE_GAP  = 2
) (
  input logic                    clk,
  input logic                    reset,
  ip_ingress_scheduler_if.slave  bus
);

  localparam int unsigned IdxW   = $clog2(NPORTS);
  localparam int unsigned StallW = (STALL_MAX > 255) ? $clog2(STALL_MAX + 1) : 8;
  localparam int unsigned GapW   = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;

  typedef enum logic [1:0] {StIdle, StHeader, StBody, StDrain} state_e;

  state_e              state_q, state_d;
  logic [NPORTS-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]     gidx_q, gidx_d;
  logic [IdxW-1:0]     rr_q, rr_d;
  logic [4:0]          byte_cnt_q, byte_cnt_d;
  logic [15:0]         tot_len_q, tot_len_d;
  logic [15:0]         body_left_q, body_left_d;
  logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [7:0]          eng_in_q, eng_in_d;
  logic                eng_ready_q, eng_ready_d;
  logic                pkt_done_q, pkt_done_d;
  logic                err_len_q, err_len_d;
  logic                err_stall_q, err_stall_d;

  logic [7:0]      cur_byte;
  logic            cur_valid;
  logic            active;
  logic            xfer;
  logic [IdxW-1:0] pick_idx;
  logic            pick_found;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int cand;
    cand       = 0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int i = 0; i < int'(NPORTS); i++) begin
      cand = int'(rr_q) + i;
      if (cand >= int'(NPORTS)) cand = cand - int'(NPORTS);
      if (!pick_found && bus.port_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_d        = rr_q;
    byte_cnt_d  = byte_cnt_q;
    tot_len_d   = tot_len_q;
    body_left_d = body_left_q;
    stall_cnt_d = stall_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pkt_done_d  = 1'b0;
    err_len_d   = 1'b0;
    err_stall_d = 1'b0;

    cur_byte  = bus.port_data[{gidx_q, 3'b000} +: 8];
    cur_valid = bus.port_valid[gidx_q];
    active    = (state_q == StHeader) || (state_q == StBody);
    xfer      = active && cur_valid && !bus.eng_busy;

    eng_ready_d = xfer;
    eng_in_d    = xfer ? cur_byte : eng_in_q;

    if (active) begin
      stall_cnt_d = (cur_valid || bus.eng_busy) ? '0 : stall_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d     = {{(NPORTS-1){1'b0}}, 1'b1} << pick_idx;
          gidx_d      = pick_idx;
          byte_cnt_d  = '0;
          stall_cnt_d = '0;
          gap_cnt_d   = '0;
          state_d     = StHeader;
        end
      end
      StHeader: begin
        if (xfer) begin
          if (byte_cnt_q == 5'd2) tot_len_d[15:8] = cur_byte;
          if (byte_cnt_q == 5'd3) tot_len_d[7:0] = cur_byte;
          // Length bytes were latched earlier in the header, so tot_len_q is final here.
          if (byte_cnt_q == 5'(HDR_BYTES - 1)) begin
            if (tot_len_q < 16'(HDR_BYTES)) begin
              err_len_d = 1'b1;
              state_d   = StDrain;
            end else begin
              body_left_d = tot_len_q - 16'(HDR_BYTES);
              state_d     = (tot_len_q == 16'(HDR_BYTES)) ? StDrain : StBody;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end
      end
      StBody: begin
        if (xfer) begin
          body_left_d = body_left_q - 16'd1;
          if (body_left_q == 16'd1) state_d = StDrain;
        end
      end
      StDrain: begin
        if (bus.eng_busy) begin
          gap_cnt_d = '0;
        end else if (gap_cnt_q == GapW'(IDLE_GAP - 1)) begin
          gap_cnt_d  = '0;
          grant_d    = '0;
          pkt_done_d = 1'b1;
          rr_d       = (gidx_q == IdxW'(NPORTS - 1)) ? '0 : gidx_q + 1'b1;
          state_d    = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (active && !xfer && (stall_cnt_d == StallW'(STALL_MAX))) begin
      err_stall_d = 1'b1;
      state_d     = StDrain;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_q        <= '0;
      byte_cnt_q  <= '0;
      tot_len_q   <= '0;
      body_left_q <= '0;
      stall_cnt_q <= '0;
      gap_cnt_q   <= '0;
      eng_in_q    <= '0;
      eng_ready_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      err_len_q   <= 1'b0;
      err_stall_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_q        <= rr_d;
      byte_cnt_q  <= byte_cnt_d;
      tot_len_q   <= tot_len_d;
      body_left_q <= body_left_d;
      stall_cnt_q <= stall_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      eng_in_q    <= eng_in_d;
      eng_ready_q <= eng_ready_d;
      pkt_done_q  <= pkt_done_d;
      err_len_q   <= err_len_d;
      err_stall_q <= err_stall_d;
    end
  end

  assign bus.port_pop  = xfer ? grant_q : '0;
  assign bus.grant     = grant_q;
  assign bus.eng_in    = eng_in_q;
  assign bus.eng_ready = eng_ready_q;
  assign bus.pkt_done  = pkt_done_q;
  assign bus.err_len   = err_len_q;
  assign bus.err_stall = err_stall_q;

endmodule

// File: tb/tb_ip_ingress_scheduler.sv
// Randomized bench for ip_ingress_scheduler: per-port byte streams, a packet-level
// round-robin model and an expected engine byte stream per port.
module tb_ip_ingress_scheduler;
  localparam int NP   = 4;
  localparam int HDR  = 20;
  localparam int SMAX = 255;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ip_ingress_scheduler_if #(.NPORTS(NP)) bus ();

  ip_ingress_scheduler #(
    .NPORTS   (NP),
    .HDR_BYTES(HDR),
    .STALL_MAX(SMAX),
    .IDLE_GAP (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] byte_q [NP][$];
  logic [7:0] exp_q  [NP][$];
  int         pkt_len_q   [NP][$];
  bit         pkt_short_q [NP][$];

  int cur_port = -1;
  int cur_left, cur_total, pop_left;
  int rr = 0;
  bit cur_short, err_len_seen, stalled, cur_stall_exp, stall_arm;
  int stall_run, stall_port = -1, stall_pulses;
  int vpct = 100, bpct = 0;
  int done_cnt, total_enq;
  logic [NP-1:0] grant_prev;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [NP-1:0] req, input int ptr);
    for (int i = 0; i < NP; i++) if (req[(ptr + i) % NP]) return (ptr + i) % NP;
    return -1;
  endfunction

  function automatic bit model_idle();
    if (cur_port >= 0) return 1'b0;
    for (int p = 0; p < NP; p++)
      if (pkt_len_q[p].size() != 0 || byte_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add_pkt(input int p, input int len);
    int         f;
    logic [7:0] b;
    logic [15:0] l16;
    l16 = 16'(len);
    f = (len < HDR) ? HDR : len;
    for (int i = 0; i < f; i++) begin
      b = (i == 2) ? l16[15:8] : (i == 3) ? l16[7:0] : 8'($urandom);
      byte_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
    pkt_len_q[p].push_back(f);
    pkt_short_q[p].push_back(len < HDR);
    total_enq++;
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++) begin
      byte_q[p].delete();
      exp_q[p].delete();
      pkt_len_q[p].delete();
      pkt_short_q[p].delete();
    end
    cur_port = -1; rr = 0; grant_prev = '0; stall_run = 0;
    cur_total = 0; pop_left = 0;
    bus.port_req = '0; bus.port_valid = '0; bus.port_data = '0; bus.eng_busy = 1'b0;
  endtask

  // One cycle: check what the last rising edge produced, then drive the next inputs.
  task automatic step();
    int e;
    bit v;
    @(negedge clk);
    if (cur_port >= 0 && pop_left > 0 && !bus.port_valid[cur_port] && !bus.eng_busy)
      stall_run++;
    else
      stall_run = 0;

    check("grant_onehot", int'($onehot0(bus.grant)), 1);
    if (bus.err_stall) begin
      stall_pulses++;
      stalled = 1'b1;
      check("stall_cycles", stall_run, SMAX);
    end
    if (bus.err_len) err_len_seen = 1'b1;
    if (bus.eng_ready) begin
      if (cur_port < 0 || exp_q[cur_port].size() == 0) begin
        check("ready_owner", 0, 1);
      end else begin
        check("eng_in", int'(bus.eng_in), int'(exp_q[cur_port].pop_front()));
        cur_left--;
      end
    end
    if (grant_prev != '0 && bus.grant != grant_prev) check("grant_hold", int'(bus.pkt_done), 1);
    if (bus.pkt_done) begin
      if (cur_port < 0) begin
        check("done_owner", 0, 1);
      end else begin
        done_cnt++;
        check("done_fwd", cur_left, pop_left);
        if (!cur_stall_exp) check("done_rem", pop_left, 0);
        check("done_err_stall", int'(stalled), int'(cur_stall_exp));
        check("done_err_len", int'(err_len_seen), int'(cur_short));
        check("done_grant", int'(bus.grant), 0);
        repeat (pop_left) if (byte_q[cur_port].size() > 0) void'(byte_q[cur_port].pop_front());
        repeat (cur_left) if (exp_q[cur_port].size() > 0) void'(exp_q[cur_port].pop_front());
        rr = (cur_port + 1) % NP;
        cur_port = -1;
      end
    end
    if (bus.grant != '0 && grant_prev == '0) begin
      e = model_pick(bus.port_req, rr);
      check("grant", int'(bus.grant), (e >= 0) ? (1 << e) : 0);
      if (e >= 0 && pkt_len_q[e].size() > 0) begin
        cur_port = e;
        cur_total = pkt_len_q[e].pop_front();
        cur_short = pkt_short_q[e].pop_front();
        cur_left = cur_total;
        pop_left = cur_total;
        err_len_seen = 1'b0;
        stalled = 1'b0;
        cur_stall_exp = stall_arm && (e == stall_port);
      end
    end
    grant_prev = bus.grant;

    for (int p = 0; p < NP; p++) begin
      bus.port_req[p] = (byte_q[p].size() > 0);
      v = (byte_q[p].size() > 0) && ($urandom_range(99) < vpct);
      if (stall_arm && p == stall_port && p == cur_port && (cur_total - pop_left) >= 22)
        v = 1'b0;
      bus.port_valid[p] = v;
      bus.port_data[p*8 +: 8] = (byte_q[p].size() > 0) ? byte_q[p][0] : 8'($urandom);
    end
    bus.eng_busy = ($urandom_range(99) < bpct);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (bus.port_pop[p]) begin
        check("pop_legal", int'(p == cur_port && bus.port_valid[p] && !bus.eng_busy && pop_left > 0), 1);
        if (p == cur_port) begin
          if (byte_q[p].size() > 0) void'(byte_q[p].pop_front());
          pop_left--;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_grant", int'(bus.grant), 0);
    check("rst_eng_ready", int'(bus.eng_ready), 0);
    check("rst_eng_in", int'(bus.eng_in), 0);
    check("rst_pkt_done", int'(bus.pkt_done), 0);
    check("rst_err_len", int'(bus.err_len), 0);
    check("rst_err_stall", int'(bus.err_stall), 0);
    check("rst_port_pop", int'(bus.port_pop), 0);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic run_idle(input int bound);
    int n = 0;
    while (!model_idle() && n < bound) begin
      step();
      n++;
    end
    check("drain_timeout", int'(model_idle()), 1);
    repeat (3) step();
  endtask

  initial begin
    bus.port_req = '0; bus.port_valid = '0; bus.port_data = '0; bus.eng_busy = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Two ports, two minimum-length packets each, unstalled.
    vpct = 100; bpct = 0;
    add_pkt(0, 20); add_pkt(0, 20); add_pkt(2, 20); add_pkt(2, 20);
    run_idle(2000);

    // Reset in the middle of a body, then a clean packet from port 1.
    add_pkt(0, 30);
    for (int k = 0; k < 200 && !(cur_port == 0 && (cur_total - pop_left) >= 27); k++) step();
    check("pre_reset_pops", cur_total - pop_left, 27);
    do_reset();
    add_pkt(1, 24);
    run_idle(2000);

    // Short header and a busy-heavy body.
    add_pkt(3, 10);
    bpct = 40;
    add_pkt(2, 45);
    run_idle(4000);

    // Random traffic across all ports.
    vpct = 80; bpct = 20;
    for (int p = 0; p < NP; p++) begin
      int npk;
      npk = $urandom_range(3);
      for (int k = 0; k < npk; k++)
        add_pkt(p, ($urandom_range(7) == 0) ? $urandom_range(19) : $urandom_range(48, 20));
    end
    run_idle(20000);

    // Granted port goes silent mid-body; another port is waiting.
    vpct = 100; bpct = 0;
    stall_arm = 1'b1; stall_port = 1; stall_pulses = 0;
    add_pkt(1, 40); add_pkt(2, 20);
    run_idle(3000);
    stall_arm = 1'b0;
    check("stall_pulses", stall_pulses, 1);
    check("pkts_done", done_cnt, total_enq - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
